// File: rtl/reply_frame_encoder.sv
// Serialises one register reply as a framed, byte-stuffed stream for a UART transmitter:
// START, header, MSB-first payload, END, with any reserved byte in the body preceded by ESC.
module reply_frame_encoder #(
    parameter logic [7:0] START_CHAR = 8'h7B,
    parameter logic [7:0] END_CHAR   = 8'h7D,
    parameter logic [7:0] ESC_CHAR   = 8'h5C
) (
    input  logic        clk_12MHz,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] reg_data,
    input  logic [2:0]  reg_size,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_START,
        SEND_ESC,
        SEND_BYTE,
        SEND_END
    } state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [2:0]  size;
    } reply_t;

    state_t     state_q, state_d;
    reply_t     req_q;
    logic [2:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic [2:0] size_clamped;
    logic [7:0] cur_byte, nxt_byte;

    // Body index 0 is the header; index k (1..size) is payload byte number size-k.
    function automatic logic [7:0] byte_at(input reply_t r, input logic [2:0] i);
        logic [2:0] sel;
        byte_at = 8'h00;
        sel     = 3'(r.size - i);
        if (i == 3'd0) begin
            byte_at = r.addr;
        end else begin
            case (sel)
                3'd0:    byte_at = r.data[7:0];
                3'd1:    byte_at = r.data[15:8];
                3'd2:    byte_at = r.data[23:16];
                3'd3:    byte_at = r.data[31:24];
                default: byte_at = 8'h00;
            endcase
        end
    endfunction

    function automatic logic is_special(input logic [7:0] b);
        is_special = (b == START_CHAR) || (b == END_CHAR) || (b == ESC_CHAR);
    endfunction

    assign size_clamped = (reg_size > 3'd4) ? 3'd4 : reg_size;
    assign cur_byte     = byte_at(req_q, idx_q);
    assign nxt_byte     = byte_at(req_q, 3'(idx_q + 3'd1));
    assign tx_valid     = (state_q != IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        tx_data = 8'h00;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND_START;
                    idx_d   = 3'd0;
                end
            end
            SEND_START: begin
                tx_data = START_CHAR;
                if (tx_ready) state_d = is_special(cur_byte) ? SEND_ESC : SEND_BYTE;
            end
            SEND_ESC: begin
                tx_data = ESC_CHAR;
                if (tx_ready) state_d = SEND_BYTE;
            end
            SEND_BYTE: begin
                tx_data = cur_byte;
                if (tx_ready) begin
                    if (idx_q == req_q.size) begin
                        state_d = SEND_END;
                    end else begin
                        idx_d   = 3'(idx_q + 3'd1);
                        state_d = is_special(nxt_byte) ? SEND_ESC : SEND_BYTE;
                    end
                end
            end
            SEND_END: begin
                tx_data = END_CHAR;
                if (tx_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_12MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            done_q  <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            if (state_q == IDLE && start) begin
                req_q.addr <= reg_addr;
                req_q.data <= reg_data;
                req_q.size <= size_clamped;
            end
        end
    end

endmodule

// File: tb/tb_reply_frame_encoder.sv
// Self-checking bench: frames are rebuilt from the framing/stuffing rules and compared with
// the bytes actually handed over on tx_valid & tx_ready, under steady and random backpressure.
module tb_reply_frame_encoder;

    logic        clk_12MHz = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  reg_addr;
    logic [31:0] reg_data;
    logic [2:0]  reg_size;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [7:0] got[$];
    logic [7:0] exp[$];
    int         stall_err;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       acc_busy, acc_valid;
    logic [7:0] acc_data;

    reply_frame_encoder dut (
        .clk_12MHz (clk_12MHz),
        .reset_n   (reset_n),
        .start     (start),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .reg_size  (reg_size),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    always #41 clk_12MHz = ~clk_12MHz;

    // Reference: frame built straight from the byte-stuffing rules.
    task automatic push_body(input logic [7:0] b);
        if (b == 8'h7B || b == 8'h7D || b == 8'h5C) exp.push_back(8'h5C);
        exp.push_back(b);
    endtask

    task automatic build_exp(input logic [7:0] a, input logic [31:0] d, input logic [2:0] s);
        int n;
        exp.delete();
        n = (s > 3'd4) ? 4 : int'(s);
        exp.push_back(8'h7B);
        push_body(a);
        for (int i = n - 1; i >= 0; i--) push_body(d[8*i +: 8]);
        exp.push_back(8'h7D);
    endtask

    function automatic string qstr(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    function automatic bit same_q(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: apply tx_ready, observe at the falling edge, return just after the rising edge.
    task automatic clk_step(input logic rdy);
        tx_ready = rdy;
        @(negedge clk_12MHz);
        if (tx_valid === 1'b1 && tx_ready) got.push_back(tx_data);
        if (prev_stall && tx_data !== prev_data) stall_err++;
        prev_stall = (tx_valid === 1'b1) && !tx_ready;
        prev_data  = tx_data;
        @(posedge clk_12MHz);
        #1;
    endtask

    // Launch a frame and run until done (bounded). mode 1 = random tx_ready gaps.
    task automatic do_frame(input logic [7:0] a, input logic [31:0] d, input logic [2:0] s,
                            input bit rnd, input bit mid_start, output int cycles);
        got.delete();
        stall_err  = 0;
        prev_stall = 1'b0;
        reg_addr = a; reg_data = d; reg_size = s;
        start = 1'b1;
        clk_step(1'b1);
        start = 1'b0;
        reg_addr = ~a; reg_data = ~d; reg_size = 3'(s + 3'd3);
        acc_busy = busy; acc_valid = tx_valid; acc_data = tx_data;
        cycles = 0;
        while (done !== 1'b1 && cycles < 300) begin
            start = (mid_start && cycles == 2) ? 1'b1 : 1'b0;
            clk_step(rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; tx_ready = 1'b0;
        reg_addr = 8'h00; reg_data = 32'h0; reg_size = 3'd0;
        repeat (3) @(posedge clk_12MHz);
        #1;
        checks++;
        if ({tx_data, tx_valid, busy, done} !== 11'h0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%02h valid=%b busy=%b done=%b, want all 0",
                     tx_data, tx_valid, busy, done);
        end
        reset_n = 1'b1;
        clk_step(1'b1);
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, want 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_basic();
        int cyc;
        build_exp(8'h12, 32'h0000ABCD, 3'd2);
        do_frame(8'h12, 32'h0000ABCD, 3'd2, 1'b0, 1'b0, cyc);
        checks++;
        if (!(acc_busy === 1'b1 && acc_valid === 1'b1 && acc_data === 8'h7B)) begin
            errors++;
            $display("FAIL accept_latency: busy=%b valid=%b data=%02h, want 1 1 7b",
                     acc_busy, acc_valid, acc_data);
        end
        checks++;
        if (!same_q(got, exp)) begin
            errors++;
            $display("FAIL basic_frame: got %s want %s", qstr(got), qstr(exp));
        end
        checks++;
        if (cyc != exp.size()) begin
            errors++;
            $display("FAIL basic_cycles: got %0d want %0d", cyc, exp.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_falls: got %b want 0", busy);
        end
        clk_step(1'b1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: got %b want 0", done);
        end
    endtask

    task automatic test_escape();
        int cyc;
        logic [7:0] a[3]   = '{8'h7B, 8'h7D, 8'h33};
        logic [31:0] d[3]  = '{32'h0000005C, 32'hFFFFFFFF, 32'h01020304};
        logic [2:0] s[3]   = '{3'd1, 3'd0, 3'd7};
        for (int i = 0; i < 3; i++) begin
            build_exp(a[i], d[i], s[i]);
            do_frame(a[i], d[i], s[i], 1'b0, 1'b0, cyc);
            checks++;
            if (!same_q(got, exp) || cyc != exp.size()) begin
                errors++;
                $display("FAIL escape_frame%0d: got %s (%0d cyc) want %s", i, qstr(got), cyc, qstr(exp));
            end
        end
    endtask

    task automatic test_stall();
        int cyc;
        for (int k = 0; k < 4; k++) begin
            logic [7:0]  a = 8'($urandom);
            logic [31:0] d = $urandom;
            if (k == 0) d = 32'h7B5C7D11;
            build_exp(a, d, 3'd4);
            do_frame(a, d, 3'd4, 1'b1, 1'b0, cyc);
            checks++;
            if (!same_q(got, exp)) begin
                errors++;
                $display("FAIL stall_frame%0d: got %s want %s", k, qstr(got), qstr(exp));
            end
            checks++;
            if (stall_err != 0) begin
                errors++;
                $display("FAIL stall_stable%0d: %0d data changes while stalled, want 0", k, stall_err);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        for (int k = 0; k < 8; k++) begin
            logic [7:0]  a = ($urandom_range(0, 3) == 0) ? 8'h5C : 8'($urandom);
            logic [31:0] d = $urandom;
            logic [2:0]  s = 3'($urandom_range(0, 7));
            bit          r = k[0];
            build_exp(a, d, s);
            do_frame(a, d, s, r, 1'b0, cyc);
            checks++;
            if (!same_q(got, exp)) begin
                errors++;
                $display("FAIL random_frame%0d: got %s want %s", k, qstr(got), qstr(exp));
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        build_exp(8'h44, 32'hA1B2C3D4, 3'd3);
        do_frame(8'h44, 32'hA1B2C3D4, 3'd3, 1'b0, 1'b1, cyc);
        checks++;
        if (!same_q(got, exp) || cyc != exp.size()) begin
            errors++;
            $display("FAIL ignore_midstart: got %s (%0d cyc) want %s", qstr(got), cyc, qstr(exp));
        end
        // done is high right now; the next edge must accept a new start.
        build_exp(8'h7D, 32'h00007B00, 3'd2);
        do_frame(8'h7D, 32'h00007B00, 3'd2, 1'b0, 1'b0, cyc);
        checks++;
        if (acc_busy !== 1'b1 || acc_data !== 8'h7B) begin
            errors++;
            $display("FAIL restart_after_done: busy=%b data=%02h want 1 7b", acc_busy, acc_data);
        end
        checks++;
        if (!same_q(got, exp)) begin
            errors++;
            $display("FAIL second_frame: got %s want %s", qstr(got), qstr(exp));
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        bit saw_end;
        got.delete();
        prev_stall = 1'b0;
        reg_addr = 8'h12; reg_data = 32'h11223344; reg_size = 3'd4;
        start = 1'b1;
        clk_step(1'b1);
        start = 1'b0;
        repeat (3) clk_step(1'b1);
        #20 reset_n = 1'b0;
        #1;
        checks++;
        if ({tx_data, tx_valid, busy, done} !== 11'h0) begin
            errors++;
            $display("FAIL async_reset: got data=%02h valid=%b busy=%b done=%b, want all 0",
                     tx_data, tx_valid, busy, done);
        end
        @(posedge clk_12MHz);
        #1;
        repeat (3) clk_step(1'b1);
        reset_n = 1'b1;
        repeat (2) clk_step(1'b1);
        saw_end = 1'b0;
        foreach (got[i]) if (got[i] == 8'h7D) saw_end = 1'b1;
        checks++;
        if (got.size() != 3 || saw_end) begin
            errors++;
            $display("FAIL reset_abandon: got %s want 7b 12 11", qstr(got));
        end
        build_exp(8'h5C, 32'h00C0FFEE, 3'd3);
        do_frame(8'h5C, 32'h00C0FFEE, 3'd3, 1'b0, 1'b0, cyc);
        checks++;
        if (!same_q(got, exp) || cyc != exp.size()) begin
            errors++;
            $display("FAIL post_reset_frame: got %s want %s", qstr(got), qstr(exp));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_escape();
        test_stall();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
